// File: rtl/ring_feedback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_feedback_pkg
// Purpose  : Shared types, widths and the ring permutation used by the
//            registered slice-ring sequencer (ring_feedback_seq).
// Contents : state_t        - sequencer states
//            RING_W         - ring vector width
//            S*_HI / S*_LO  - bounds of the four ring slices
//            ring_step()    - one permutation step of the ring
// Revision : 1.0 - initial release
// ============================================================================
package ring_feedback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RING_W = 10;

    // Ring slices: S0=[1:0], S1=[3:2], S2=[7:4], S3=[9:8]
    localparam int S0_LO = 0;
    localparam int S0_HI = 1;
    localparam int S1_LO = 2;
    localparam int S1_HI = 3;
    localparam int S2_LO = 4;
    localparam int S2_HI = 7;
    localparam int S3_LO = 8;
    localparam int S3_HI = 9;
    // Only the low two bits of S2 feed S3; the upper two are dropped each step
    localparam int S2_FEED_HI = S2_LO + 1;

    // One ring step; every slice reads the pre-step vector.
    function automatic logic [RING_W-1:0] ring_step(input logic [RING_W-1:0] v);
        logic [RING_W-1:0] r;
        r = '0;
        r[S0_HI:S0_LO] = v[S3_HI:S3_LO];
        r[S1_HI:S1_LO] = v[S0_HI:S0_LO];
        r[S2_HI:S2_LO] = {2'b00, v[S1_HI:S1_LO]};
        r[S3_HI:S3_LO] = v[S2_FEED_HI:S2_LO];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_feedback_seq_xcouple.sv
`default_nettype none
// ============================================================================
// Module   : xcouple_reg
// Purpose  : Registered cross-coupled mux pair. Each output flop selects
//            either its own data input or the other flop's current value,
//            so the a/b feedback loop is always broken by a register.
// Ports    : clk    in  1  clock, posedge
//            rst_n  in  1  asynchronous active-low reset
//            en     in  1  update enable (pair holds when low)
//            ia,ib  in  1  data inputs
//            sa,sb  in  1  selects (1 = take own data input)
//            oa,ob  out 1  registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module xcouple_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ia,
    input  logic ib,
    input  logic sa,
    input  logic sb,
    output logic oa,
    output logic ob
);

    // Both right-hand sides read the pre-edge values, giving a true swap
    // when both selects are low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oa <= 1'b0;
            ob <= 1'b0;
        end else if (en) begin
            oa <= sa ? ia : ob;
            ob <= sb ? ib : oa;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_feedback_seq.sv
`default_nettype none
// ============================================================================
// Module   : ring_feedback_seq
// Purpose  : Loads a 10-bit seed over valid/ready, applies the slice-ring
//            permutation STEPS times, then presents the result over
//            valid/ready. A registered cross-coupled pair runs alongside.
// Ports    : clk        in  1   clock, posedge
//            rst_n      in  1   asynchronous active-low reset
//            in_valid   in  1   seed valid
//            in_ready   out 1   high only in IDLE
//            in_seed    in  10  ring seed
//            ia,ib      in  1   cross-pair data inputs
//            sa,sb      in  1   cross-pair selects
//            out_valid  out 1   result valid (DONE)
//            out_ready  in  1   result accepted
//            o          out 10  ring state
//            oa,ob      out 1   registered cross-pair outputs
//            par        out 1   registered ^o (only with RING_PARITY_EN)
// Config   : RING_PARITY_EN - adds the registered parity output par
// Revision : 1.0 - initial release
// ============================================================================
module ring_feedback_seq
    import ring_feedback_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RING_W-1:0] in_seed,
    input  logic              ia,
    input  logic              ib,
    input  logic              sa,
    input  logic              sb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RING_W-1:0] o,
    output logic              oa,
`ifdef RING_PARITY_EN
    output logic              ob,
    output logic              par
`else
    output logic              ob
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [RING_W-1:0] r_o;
    logic [RING_W-1:0] w_ring_next;
    logic              w_load;
    logic              w_run;

    assign w_load      = (r_state == IDLE) && in_valid;
    assign w_run       = (r_state == RUN);
    assign w_ring_next = ring_step(r_o);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs depend on state only, so no input reaches an output
    // combinationally.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- Ring datapath ----------------
    // cnt peaks at STEPS (<= 255) on the final step, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_o   <= in_seed;
            r_cnt <= '0;
        end else if (w_run) begin
            r_o   <= w_ring_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o = r_o;

`ifdef RING_PARITY_EN
    logic r_par;

    // Parity is registered alongside o from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^in_seed;
        end else if (w_run) begin
            r_par <= ^w_ring_next;
        end
    end

    assign par = r_par;
`else
    // Parity output and flop are not built in this configuration.
`endif

    // ---------------- Cross-coupled pair ----------------
    xcouple_reg u_xcouple (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .ia    (ia),
        .ib    (ib),
        .sa    (sa),
        .sb    (sb),
        .oa    (oa),
        .ob    (ob)
    );

endmodule
`default_nettype wire
